// File: rtl/fpga_cfg_pkg.sv
// Shared types and defaults for the fabric configuration-chain loader.
// Holds the loader state encoding and the readback flush alignment helper.
package fpga_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } cfg_state_t;

   localparam int DEF_CHAIN_LEN = 1024;
   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_CNT_W     = 16;

   // n samples sit in the low bits of sr; move them to the top, zero-fill below
   function automatic logic [7:0] left_align(input logic [7:0] sr, input logic [2:0] n);
      logic [3:0] sh;
      sh = 4'd8 - {1'b0, n};
      return sr << sh;
   endfunction

endpackage

// File: rtl/fpga_cfg_phase_div.sv
// Phase timer for prog_clk: a down-counter that reloads every CLK_DIV cycles and
// emits a one-cycle rise or fall strobe at terminal count, depending on the current level.
module fpga_cfg_phase_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic phase_hi,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int             PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PH_W-1:0] RELOAD = PH_W'(CLK_DIV - 1);

   logic [PH_W-1:0] ph_cnt;
   logic            tc;

   assign tc       = en && (ph_cnt == '0);
   assign rise_stb = tc && !phase_hi;
   assign fall_stb = tc && phase_hi;

   // Held at reload while disabled so the first phase after a handshake is full length
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_cnt <= RELOAD;
      end else if (!en || tc) begin
         ph_cnt <= RELOAD;
      end else begin
         ph_cnt <= ph_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration-chain programmer: serializes host bytes MSB-first onto ccff_head with
// generated prog_clk, and packs ccff_tail samples into readback bytes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start
// WAIT     | pass active, in_ready high, waiting for the next byte
// SHIFT_LO | prog_clk low, ccff_head set up for the current bit
// SHIFT_HI | prog_clk high, bit clocked into the chain
// DONE     | CHAIN_LEN bits shifted; waiting for the next start
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             prog_clk,
   output logic             ccff_head,
   input  logic             ccff_tail,
   output logic [7:0]       rb_data,
   output logic             rb_valid,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);

   cfg_state_t state, state_nxt;

   logic [7:0] byte_sr;
   logic [2:0] bit_idx;
   logic [7:0] rb_sr;
   logic [2:0] rb_cnt;
   logic       rise_stb;
   logic       fall_stb;
   logic       shifting;
   logic       start_ok;
   logic       hs;
   logic       at_end;

   assign shifting = (state == SHIFT_LO) || (state == SHIFT_HI);
   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign in_ready = (state == WAIT);
   assign hs       = in_ready && in_valid;
   assign at_end   = (bit_cnt == CHAIN_END);

   fpga_cfg_phase_div #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (shifting),
      .phase_hi (prog_clk),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) state_nxt = WAIT;
         end
         WAIT: begin
            if (in_valid) state_nxt = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (rise_stb) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (fall_stb) begin
               if (at_end)                state_nxt = DONE;
               else if (bit_idx == 3'd7)  state_nxt = WAIT;
               else                       state_nxt = SHIFT_LO;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_clk  <= 1'b0;
         ccff_head <= 1'b0;
         byte_sr   <= '0;
         bit_idx   <= '0;
         bit_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rb_sr     <= '0;
         rb_cnt    <= '0;
         rb_data   <= '0;
         rb_valid  <= 1'b0;
      end else begin
         rb_valid <= 1'b0;

         if (start_ok) begin
            bit_cnt <= '0;
            done    <= 1'b0;
            busy    <= 1'b1;
            rb_sr   <= '0;
            rb_cnt  <= '0;
         end

         if (hs) begin
            byte_sr   <= in_data;
            ccff_head <= in_data[7];
            bit_idx   <= '0;
         end

         // Rising phase: the chain shifts, so ccff_tail still shows the pre-shift bit
         if (rise_stb) begin
            prog_clk <= 1'b1;
            bit_cnt  <= bit_cnt + 1'b1;
            rb_sr    <= {rb_sr[6:0], ccff_tail};
            rb_cnt   <= rb_cnt + 1'b1;
            if (rb_cnt == 3'd7) begin
               rb_data  <= {rb_sr[6:0], ccff_tail};
               rb_valid <= 1'b1;
            end
         end

         if (fall_stb) begin
            prog_clk <= 1'b0;
            if (at_end) begin
               busy <= 1'b0;
               done <= 1'b1;
               if (rb_cnt != 3'd0) begin
                  rb_data  <= left_align(rb_sr, rb_cnt);
                  rb_valid <= 1'b1;
                  rb_cnt   <= '0;
               end
            end else if (bit_idx != 3'd7) begin
               byte_sr   <= {byte_sr[6:0], 1'b0};
               ccff_head <= byte_sr[6];
               bit_idx   <= bit_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: four instances with different chain lengths/dividers,
// each closed by a loopback chain model (tail = head delayed 8 prog_clk rises).
module tb_fpga_cfg_loader;

   localparam int NDUT = 4;

   function automatic int cl_of(input int g);
      case (g)
         0:       return 16;
         1:       return 24;
         2:       return 12;
         default: return 20;
      endcase
   endfunction

   function automatic int cd_of(input int g);
      return (g == 3) ? 1 : 2;
   endfunction

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;

   always #5 clk = ~clk;

   logic        pc   [NDUT];
   logic        head [NDUT];
   logic        rdy  [NDUT];
   logic        rbv  [NDUT];
   logic        dn   [NDUT];
   logic        bz   [NDUT];
   logic        tail [NDUT];
   logic [7:0]  rbd  [NDUT];
   logic [15:0] bc   [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      logic       pcg;
      logic [7:0] lb;
      assign pcg     = pc[g];
      assign tail[g] = lb[7];
      always @(posedge pcg or negedge rst_n) begin
         if (!rst_n) lb <= 8'h00;
         else        lb <= {lb[6:0], head[g]};
      end
      fpga_cfg_loader #(
         .CHAIN_LEN (cl_of(g)),
         .CLK_DIV   (cd_of(g)),
         .CNT_W     (16)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start),
         .in_data   (in_data),
         .in_valid  (in_valid),
         .in_ready  (rdy[g]),
         .prog_clk  (pc[g]),
         .ccff_head (head[g]),
         .ccff_tail (tail[g]),
         .rb_data   (rbd[g]),
         .rb_valid  (rbv[g]),
         .bit_cnt   (bc[g]),
         .busy      (bz[g]),
         .done      (dn[g])
      );
   end

   int sel = 0;
   logic        s_pc, s_head, s_rdy, s_rbv, s_dn, s_bz;
   logic [7:0]  s_rbd;
   logic [15:0] s_bc;
   assign s_pc   = pc[sel];
   assign s_head = head[sel];
   assign s_rdy  = rdy[sel];
   assign s_rbv  = rbv[sel];
   assign s_dn   = dn[sel];
   assign s_bz   = bz[sel];
   assign s_rbd  = rbd[sel];
   assign s_bc   = bc[sel];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (dut %0d, t=%0t)", name, act, exp, sel, $time);
      end
   endtask

   // ---------------- monitor on the selected instance ----------------
   int         mon_rises = 0;
   int         last_rise = 0;
   int         stable = 0;
   int         cyc = 0;
   logic       p_pc = 1'b0, p_head = 1'b0, p_rdy = 1'b0, p_rbv = 1'b0;
   bit         head_q[$];
   logic [7:0] rb_q[$];

   task automatic mon_clear();
      mon_rises = 0;
      head_q.delete();
      rb_q.delete();
   endtask

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         p_pc = 1'b0; p_head = 1'b0; p_rdy = 1'b0; p_rbv = 1'b0; stable = 0;
      end else begin
         if (s_head !== p_head) begin
            chk("head_change_timing", ((p_pc && !s_pc) || p_rdy), 1);
            stable = 0;
         end else begin
            stable++;
         end
         if (s_pc && !p_pc) begin
            if (mon_rises % 8 != 0) chk("rise_interval", cyc - last_rise, 2 * cd_of(sel));
            chk("head_setup", (stable >= cd_of(sel)), 1);
            mon_rises++;
            chk("bit_cnt_at_rise", s_bc, mon_rises);
            head_q.push_back(s_head);
            last_rise = cyc;
         end
         if (s_rbv) begin
            chk("rb_valid_single", p_rbv, 0);
            rb_q.push_back(s_rbd);
         end
         p_pc = s_pc; p_head = s_head; p_rdy = s_rdy; p_rbv = s_rbv;
      end
   end

   // ---------------- stimulus helpers and reference model ----------------
   logic [7:0] tx[$];
   bit         exp_head[$];
   logic [7:0] exp_rb[$];

   task automatic do_reset(input int d);
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      sel = d;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic feed(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) @(negedge clk);
      in_data = b;
      in_valid = 1'b1;
      t = 0;
      while (!s_rdy && !s_dn && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("feed_handshake", (s_rdy || s_dn), 1);
      if (s_rdy) @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Expected chain traffic from the byte list: bits MSB-first cut at CHAIN_LEN;
   // readback sees the same bits 8 rises late, grouped in eights, tail left-aligned.
   task automatic build_exp(input int cl);
      logic [7:0] acc;
      int n;
      bit s;
      exp_head.delete();
      exp_rb.delete();
      for (int i = 0; i < cl; i++) exp_head.push_back(tx[i / 8][7 - (i % 8)]);
      acc = 8'h00;
      n = 0;
      for (int i = 0; i < cl; i++) begin
         s = (i >= 8) ? exp_head[i - 8] : 1'b0;
         acc = {acc[6:0], s};
         n++;
         if (n == 8) begin
            exp_rb.push_back(acc);
            acc = 8'h00;
            n = 0;
         end
      end
      if (n > 0) exp_rb.push_back(acc << (8 - n));
   endtask

   task automatic run_pass(input int gap_max, input bit mid_start, input string tag);
      int t;
      int bad;
      mon_clear();
      pulse_start();
      chk({tag, "_busy_after_start"}, s_bz, 1);
      chk({tag, "_done_after_start"}, s_dn, 0);
      chk({tag, "_bitcnt_after_start"}, s_bc, 0);
      chk({tag, "_ready_in_wait"}, s_rdy, 1);
      for (int i = 0; i < tx.size(); i++) begin
         if (s_dn) break;
         feed(tx[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
         if (mid_start && i == 1) begin
            t = 0;
            while (!(s_bc == 16'd9 && !s_pc) && t < 200) begin
               @(negedge clk);
               t++;
            end
            chk({tag, "_mid_reach"}, (t < 200), 1);
            pulse_start();
            chk({tag, "_mid_bitcnt_kept"}, (s_bc >= 16'd9), 1);
            chk({tag, "_mid_busy"}, s_bz, 1);
         end
      end
      t = 0;
      while (!s_dn && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_done"}, s_dn, 1);
      repeat (3) @(negedge clk);
      chk({tag, "_rises"}, mon_rises, exp_head.size());
      bad = -1;
      for (int i = 0; i < exp_head.size() && i < head_q.size(); i++)
         if (head_q[i] !== exp_head[i] && bad < 0) bad = i;
      chk({tag, "_head_first_bad_idx"}, bad, -1);
      chk({tag, "_rb_count"}, rb_q.size(), exp_rb.size());
      for (int j = 0; j < exp_rb.size() && j < rb_q.size(); j++)
         chk($sformatf("%s_rb%0d", tag, j), rb_q[j], exp_rb[j]);
      chk({tag, "_bit_cnt_end"}, s_bc, cl_of(sel));
      chk({tag, "_busy_end"}, s_bz, 0);
      chk({tag, "_prog_clk_end"}, s_pc, 0);
      chk({tag, "_ready_end"}, s_rdy, 0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      int          dut;
      int          nb;
      logic [23:0] bytes;
      int          nbits;
      logic [23:0] head;
      int          nrb;
      logic [23:0] rb;
   } vec_t;

   vec_t vt[3];

   initial begin
      int t;
      int bad;
      int nb;

      vt[0] = '{dut: 0, nb: 2, bytes: 24'hA53C00, nbits: 16, head: 24'hA53C00, nrb: 2, rb: 24'h00A500};
      vt[1] = '{dut: 1, nb: 3, bytes: 24'h123456, nbits: 24, head: 24'h123456, nrb: 3, rb: 24'h001234};
      vt[2] = '{dut: 2, nb: 2, bytes: 24'hFFF000, nbits: 12, head: 24'hFFF000, nrb: 2, rb: 24'h00F000};

      // Reset values while rst_n is low
      #1;
      chk("rst_prog_clk", s_pc, 0);
      chk("rst_head", s_head, 0);
      chk("rst_ready", s_rdy, 0);
      chk("rst_rb_valid", s_rbv, 0);
      chk("rst_rb_data", s_rbd, 0);
      chk("rst_bit_cnt", s_bc, 0);
      chk("rst_busy", s_bz, 0);
      chk("rst_done", s_dn, 0);

      for (int v = 0; v < 3; v++) begin
         do_reset(vt[v].dut);
         tx.delete();
         exp_head.delete();
         exp_rb.delete();
         for (int j = 0; j < vt[v].nb; j++) tx.push_back(vt[v].bytes[23 - 8 * j -: 8]);
         for (int k = 0; k < vt[v].nbits; k++) exp_head.push_back(vt[v].head[23 - k]);
         for (int j = 0; j < vt[v].nrb; j++) exp_rb.push_back(vt[v].rb[23 - 8 * j -: 8]);
         run_pass(0, 1'b0, $sformatf("vec%0d", v));
      end

      // Randomized passes against the model
      for (int r = 0; r < 8; r++) begin
         do_reset((r % 2) ? 3 : 1);
         tx.delete();
         nb = (cl_of(sel) + 7) / 8;
         for (int j = 0; j < nb; j++) tx.push_back(8'($urandom_range(0, 255)));
         build_exp(cl_of(sel));
         run_pass(3, 1'b0, $sformatf("rnd%0d", r));
      end

      // in_valid held low in WAIT
      do_reset(1);
      mon_clear();
      pulse_start();
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (s_pc !== 1'b0 || s_rdy !== 1'b1 || s_bz !== 1'b1) bad++;
      end
      chk("wait_idle_bad_cycles", bad, 0);
      chk("wait_idle_rises", mon_rises, 0);

      // start during SHIFT_LO ignored; then start from DONE restarts cleanly
      do_reset(1);
      tx.delete();
      tx.push_back(8'h12);
      tx.push_back(8'h34);
      tx.push_back(8'h56);
      build_exp(24);
      run_pass(0, 1'b1, "mid");
      pulse_start();
      chk("restart_done_cleared", s_dn, 0);
      chk("restart_bit_cnt", s_bc, 0);
      chk("restart_busy", s_bz, 1);
      chk("restart_ready", s_rdy, 1);

      // Reset during SHIFT_HI
      do_reset(1);
      mon_clear();
      pulse_start();
      feed(8'hC3, 0);
      t = 0;
      while (!s_pc && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("rstmid_reach_hi", s_pc, 1);
      chk("rstmid_head_before", s_head, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_prog_clk", s_pc, 0);
      chk("rstmid_head", s_head, 0);
      chk("rstmid_busy", s_bz, 0);
      chk("rstmid_done", s_dn, 0);
      chk("rstmid_bit_cnt", s_bc, 0);
      chk("rstmid_ready", s_rdy, 0);
      chk("rstmid_rb_valid", s_rbv, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mon_clear();
      repeat (20) @(negedge clk);
      chk("rstmid_no_rise_after", mon_rises, 0);
      chk("rstmid_prog_clk_after", s_pc, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
